// File: rtl/secure_mem_pkg.sv
// Shared types and default sizes for the secure key/ID memory front-end.
// Holds the controller state encoding, the 2-bit response error codes and
// the default geometry of the memory it sits in front of.
package secure_mem_pkg;

    // Default geometry: 6 entries of 512 bits, written 256 bits at a time.
    localparam int SMC_WIDTH  = 512;
    localparam int SMC_LENGTH = 6;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    // Error code reported alongside every response.
    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_LOCKED  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

endpackage

// File: rtl/secure_mem_ctrl.sv
// secure_mem_ctrl: request/response front-end for the secure key/ID memory.
// Turns a valid/ready request stream into single-cycle memory strobes,
// captures read data on the memory's valid pulse and holds each response
// until the consumer takes it. Adds range checking, a sticky write lock over
// the key region (addresses >= PROT_BASE) and a read timeout.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_write           1 = write, 0 = read
//   req_addr            entry address
//   req_wdata           write data (half an entry wide)
//   lock_set            pulse that sets the sticky key lock
//   locked              current lock state
//   resp_valid/ready    response handshake
//   resp_data           read data, 0 for writes and errors
//   resp_err            0 OK, 1 RANGE, 2 LOCKED, 3 TIMEOUT
//   mem_rd_en/mem_wr_en single-cycle memory strobes
//   mem_addr/mem_wrData address and write data held for the memory
//   mem_rdData/_valid   registered read data from the memory
module secure_mem_ctrl
    import secure_mem_pkg::*;
#(
    parameter int WIDTH     = SMC_WIDTH,
    parameter int LENGTH    = SMC_LENGTH,
    parameter int PROT_BASE = 1,
    parameter int TIMEOUT   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [$clog2(LENGTH)-1:0] req_addr,
    input  logic [WIDTH/2-1:0]        req_wdata,
    input  logic                      lock_set,
    output logic                      locked,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WIDTH-1:0]          resp_data,
    output logic [1:0]                resp_err,
    output logic                      mem_rd_en,
    output logic                      mem_wr_en,
    output logic [$clog2(LENGTH)-1:0] mem_addr,
    output logic [WIDTH/2-1:0]        mem_wrData,
    input  logic [WIDTH-1:0]          mem_rdData,
    input  logic                      mem_rdData_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    err_t                err_q;
    logic [CW-1:0]       tmo_cnt;
    logic                tmo_hit;
    logic                range_bad;
    logic                lock_bad;

    // Addresses are widened to int so that non-power-of-two LENGTH values
    // still flag the representable but nonexistent entries. The lock check
    // uses the registered lock, so a lock_set arriving with a write does not
    // block that write.
    assign range_bad = int'(req_addr) >= LENGTH;
    assign lock_bad  = req_write && locked && (int'(req_addr) >= PROT_BASE);
    assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT - 1));
    assign resp_err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes and handshakes are decoded purely from the state, so each
    // strobe lasts exactly the single cycle spent in WRITE or RD_ISSUE.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (range_bad || lock_bad) begin
                        state_d = RESP;
                    end else if (req_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WRITE: begin
                mem_wr_en = 1'b1;
                state_d   = RESP;
            end
            RD_ISSUE: begin
                mem_rd_en = 1'b1;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rdData_valid || tmo_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: request capture at acceptance, read-data capture while
    // waiting (the memory zeroes its output once rd_en drops), the timeout
    // counter, and the sticky lock. resp_data is cleared at acceptance so
    // writes, errors and timeouts all report zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked     <= 1'b0;
            resp_data  <= '0;
            err_q      <= ERR_OK;
            mem_addr   <= '0;
            mem_wrData <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (lock_set) begin
                locked <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr   <= req_addr;
                        mem_wrData <= req_wdata;
                        resp_data  <= '0;
                        if (range_bad) begin
                            err_q <= ERR_RANGE;
                        end else if (lock_bad) begin
                            err_q <= ERR_LOCKED;
                        end else begin
                            err_q <= ERR_OK;
                        end
                    end
                end
                RD_ISSUE: begin
                    tmo_cnt <= '0;
                end
                RD_WAIT: begin
                    if (mem_rdData_valid) begin
                        resp_data <= mem_rdData;
                        err_q     <= ERR_OK;
                    end else if (tmo_hit) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/secure_mem_ctrl.md
Name: secure_mem_ctrl

Overview:
- Request/response front-end that sits directly upstream of the secure key/ID memory, which is 6 × 512-bit entries: 256-bit write port, 512-bit read port, 1-cycle registered read.
- Turns a valid/ready request stream from the security controller into single-cycle memory rd_en/wr_en pulses.
- Captures read data on the memory's valid pulse and holds it until the consumer accepts it.
- Enforces address-range checks, a sticky write-lock over the key region, and a read timeout.

Parameters:
- WIDTH, 512, memory read word width; write word is WIDTH/2.
- LENGTH, 6, number of memory entries.
- PROT_BASE, 1, first address of the key region that is write-protected once locked.
- TIMEOUT, 4, maximum cycles to wait for mem_rdData_valid after a read pulse.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  $clog2(LENGTH)  entry address
- req_wdata  in  WIDTH/2  write data
- lock_set  in  1  one-cycle pulse that sets the sticky key lock
- locked  out  1  current lock state
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_data  out  WIDTH  read data; 0 for writes and errors
- resp_err  out  2  0 OK, 1 RANGE, 2 LOCKED, 3 TIMEOUT
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  $clog2(LENGTH)  memory address
- mem_wrData  out  WIDTH/2  memory write data
- mem_rdData  in  WIDTH  memory read data
- mem_rdData_valid  in  1  memory read-data valid

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, locked = 0, resp_valid = 0, resp_data = 0, resp_err = 0.
  - mem_rd_en = mem_wr_en = 0, mem_addr = 0, mem_wrData = 0, timeout counter = 0.
  - Reset mid-transaction drops the transaction; no response is produced.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP.
- req_ready = 1 only in IDLE. A request is accepted on req_valid & req_ready; addr, write flag and wdata are registered.
- Checks at acceptance, in priority order:
  - addr >= LENGTH → RESP, err RANGE.
  - Write with locked = 1 and addr >= PROT_BASE → RESP, err LOCKED.
  - Otherwise a legal write → WRITE; a legal read → RD_ISSUE.
- WRITE: mem_wr_en = 1 for exactly one cycle with mem_addr and mem_wrData (zero-extension into the entry is the memory's concern). Next state RESP, err OK, data 0.
- RD_ISSUE: mem_rd_en = 1 for exactly one cycle. Next state RD_WAIT; counter cleared.
- RD_WAIT:
  - mem_rd_en = 0.
  - If mem_rdData_valid = 1, capture mem_rdData into resp_data → RESP, err OK.
  - Otherwise increment the counter; when it reaches TIMEOUT → RESP, err TIMEOUT, data 0.
  - The capture must be taken in this state because the memory zeroes rdData once rd_en is low.
- Strobe rules: mem_rd_en and mem_wr_en are never high together and never high outside WRITE/RD_ISSUE.
- RESP:
  - resp_valid = 1; resp_data and resp_err are stable until resp_valid & resp_ready, then → IDLE.
  - resp_ready is ignored outside RESP.
  - A back-to-back request can be accepted the cycle after the handshake, not in the same cycle.
- Latency from acceptance edge to resp_valid: read 3 cycles (nominal), write 2, error 1.
- Lock: locked is set on lock_set in any state and is cleared only by reset.
  - A lock_set in the same cycle as write acceptance does not affect that write, because the check uses the pre-update lock value.
  - Address 0 (chip ID) is always writable.
- Address width: if LENGTH is not a power of two, out-of-range addresses are representable and must return RANGE without any memory strobe.

Decomposition:
- Shared package secure_mem_pkg holds:
  - state enum (IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP);
  - 2-bit error-code enum (ERR_OK, ERR_RANGE, ERR_LOCKED, ERR_TIMEOUT);
  - default WIDTH/LENGTH constants.
- Single flat module. The timeout counter is inline, so no sub-module is needed.

Test Plan:
- Read after reset: req read addr 2, resp_ready = 1.
  → one mem_rd_en pulse; resp_valid 3 cycles after accept; resp_data = entry 2 value (512'h4319…7c0b); err 0.
- Write then read: write addr 0 wdata 256'hA5…A5, then read addr 0.
  → one mem_wr_en pulse; write resp err 0, data 0; read returns {256'h0, 256'hA5…A5}.
- Lock: pulse lock_set, then write addr 3.
  → no mem strobe, resp_err 2 after 1 cycle; write addr 0 still succeeds with err 0; locked stays 1 until rst_n.
- Range: read addr 6, then addr 7.
  → resp_err 1 for both, resp_data 0, no strobes.
- Timeout: memory model holds rdData_valid low.
  → resp_err 3 after TIMEOUT (4) cycles in RD_WAIT, resp_data 0.
- Backpressure and reset:
  - Hold resp_ready low for 5 cycles: resp_data/err stable, req_ready 0, new requests not accepted.
  - Assert rst_n low during RD_WAIT: all outputs return to reset values immediately and no response follows.
